// File: rtl/bkm_step_sequencer.sv
// bkm_step_sequencer: runs a BKM step datapath N_ITER times on a CSD operand pair with valid/ready in and out
module bkm_step_sequencer #(
    parameter int W      = 64,
    parameter int N_ITER = 64,
    parameter int NW     = 7
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*W-1:0]    X0_csd,
    input  logic [2*W-1:0]    Y0_csd,
    output logic [NW-1:0]     step_n,
    output logic [2*W-1:0]    step_X_n_csd,
    output logic [2*W-1:0]    step_Y_n_csd,
    input  logic [2*W-1:0]    step_X_np1_csd,
    input  logic [2*W-1:0]    step_Y_np1_csd,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    X_res_csd,
    output logic [2*W-1:0]    Y_res_csd
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [NW-1:0] LAST = NW'(N_ITER - 1);
    state_t          state, state_nxt;
    logic [NW-1:0]   n_reg, n_nxt;
    logic [2*W-1:0]  x_reg, y_reg, x_nxt, y_nxt;
    assign in_ready     = (state == IDLE) & enable;
    assign out_valid    = (state == DONE) & enable;
    assign busy         = (state == RUN);
    assign step_n       = n_reg;
    assign step_X_n_csd = x_reg;
    assign step_Y_n_csd = y_reg;
    assign X_res_csd    = x_reg;
    assign Y_res_csd    = y_reg;
    // next state: everything holds unless enabled; load on accept, iterate in RUN, release on result handshake
    always_comb begin
        state_nxt = state;
        n_nxt     = n_reg;
        x_nxt     = x_reg;
        y_nxt     = y_reg;
        if (enable) begin
            case (state)
                IDLE: if (in_valid) begin
                    state_nxt = RUN;
                    n_nxt     = '0;
                    x_nxt     = X0_csd;
                    y_nxt     = Y0_csd;
                end
                RUN: begin
                    x_nxt     = step_X_np1_csd;
                    y_nxt     = step_Y_np1_csd;
                    state_nxt = (n_reg == LAST) ? DONE : RUN;
                    n_nxt     = (n_reg == LAST) ? n_reg : n_reg + 1'b1;
                end
                DONE: state_nxt = out_ready ? IDLE : DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end
    // state and operand registers with synchronous reset taking priority over the stall
    always_ff @(posedge clk) begin
        if (srst) begin
            state <= IDLE;
            n_reg <= '0;
            x_reg <= '0;
            y_reg <= '0;
        end else begin
            state <= state_nxt;
            n_reg <= n_nxt;
            x_reg <= x_nxt;
            y_reg <= y_nxt;
        end
    end
endmodule

// File: tb/tb_bkm_step_sequencer.sv
// tb_bkm_step_sequencer: directed checks of the BKM step sequencer with an increment/xor step stub
module tb_bkm_step_sequencer;
    logic       clk = 0;
    logic       srst, enable, in_valid, out_ready;
    logic [7:0] X0, Y0, xn, yn, xr, yr;
    logic       in_ready, busy, out_valid;
    logic [6:0] sn;
    logic       in_valid1, in_ready1, busy1, out_valid1;
    logic [7:0] X01, Y01, xn1, yn1, xr1, yr1;
    logic [2:0] sn1;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    bkm_step_sequencer #(.W(4), .N_ITER(4), .NW(7)) dut (
        .clk(clk), .srst(srst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .X0_csd(X0), .Y0_csd(Y0), .step_n(sn), .step_X_n_csd(xn), .step_Y_n_csd(yn),
        .step_X_np1_csd(xn + 8'd1), .step_Y_np1_csd(yn ^ 8'h01), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .X_res_csd(xr), .Y_res_csd(yr)
    );

    bkm_step_sequencer #(.W(4), .N_ITER(1), .NW(3)) dut1 (
        .clk(clk), .srst(srst), .enable(enable), .in_valid(in_valid1), .in_ready(in_ready1),
        .X0_csd(X01), .Y0_csd(Y01), .step_n(sn1), .step_X_n_csd(xn1), .step_Y_n_csd(yn1),
        .step_X_np1_csd(xn1 + 8'd1), .step_Y_np1_csd(yn1 ^ 8'h01), .busy(busy1),
        .out_valid(out_valid1), .out_ready(1'b1), .X_res_csd(xr1), .Y_res_csd(yr1)
    );

    task automatic accept(input logic [7:0] x, input logic [7:0] y);
        X0 = x; Y0 = y; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        srst = 1; enable = 1; in_valid = 0; out_ready = 1; X0 = 8'hAA; Y0 = 8'h55;
        in_valid1 = 0; X01 = 0; Y01 = 0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_flags busy=%b out_valid=%b exp 0/0", busy, out_valid); end
        checks++; if (sn !== 7'd0 || xr !== 8'h00 || yr !== 8'h00) begin failures++; $display("FAIL reset_data n=%0d x=%h y=%h exp 0/00/00", sn, xr, yr); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        enable = 0; #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        enable = 1; srst = 0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int n;
        accept(8'h10, 8'h20);
        for (int i = 0; i < 4; i++) begin
            checks++; if (busy !== 1'b1 || sn !== 7'(i) || out_valid !== 1'b0 || xr !== 8'h10 + 8'(i))
                begin failures++; $display("FAIL single_run%0d busy=%b n=%0d ov=%b x=%h exp 1/%0d/0/%h", i, busy, sn, out_valid, xr, i, 8'h10 + 8'(i)); end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL single_done ov=%b busy=%b ir=%b exp 1/0/0", out_valid, busy, in_ready); end
        checks++; if (xr !== 8'h14 || yr !== 8'h20) begin failures++; $display("FAIL single_result x=%h y=%h exp 14/20", xr, yr); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL single_release ov=%b ir=%b exp 0/1", out_valid, in_ready); end
        accept(8'h10, 8'h20);
        wait_done(n);
        checks++; if (n !== 4) begin failures++; $display("FAIL single_latency got=%0d exp=4", n); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int n;
        logic ok;
        out_ready = 0;
        accept(8'h10, 8'h20);
        wait_done(n);
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || xr !== 8'h14 || yr !== 8'h20 || in_ready !== 1'b0) ok = 0;
            @(negedge clk);
        end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_hold stable=%b exp=1 (last ov=%b x=%h y=%h ir=%b)", ok, out_valid, xr, yr, in_ready); end
        out_ready = 1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_still_valid got=%b exp=1", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release ov=%b ir=%b exp 0/1", out_valid, in_ready); end
    endtask

    task automatic test_stall;
        int n;
        logic ok;
        accept(8'h10, 8'h20);
        repeat (2) @(negedge clk);
        checks++; if (sn !== 7'd2) begin failures++; $display("FAIL stall_pre n=%0d exp=2", sn); end
        enable = 0;
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sn !== 7'd2 || xr !== 8'h12 || busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) ok = 0;
        end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_freeze stable=%b exp=1 (n=%0d x=%h busy=%b)", ok, sn, xr, busy); end
        enable = 1;
        wait_done(n);
        checks++; if (n !== 2) begin failures++; $display("FAIL stall_resume cycles=%0d exp=2", n); end
        checks++; if (xr !== 8'h14 || yr !== 8'h20) begin failures++; $display("FAIL stall_result x=%h y=%h exp 14/20", xr, yr); end
        enable = 0; #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_done_ov got=%b exp=0", out_valid); end
        @(negedge clk);
        enable = 1; #1;
        checks++; if (out_valid !== 1'b1 || xr !== 8'h14) begin failures++; $display("FAIL stall_done_hold ov=%b x=%h exp 1/14", out_valid, xr); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        accept(8'h10, 8'h20);
        @(negedge clk);
        checks++; if (sn !== 7'd1) begin failures++; $display("FAIL rmid_pre n=%0d exp=1", sn); end
        srst = 1;
        @(negedge clk);
        srst = 0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || xr !== 8'h00 || in_ready !== 1'b1 || sn !== 7'd0)
            begin failures++; $display("FAIL rmid_clear busy=%b ov=%b x=%h ir=%b n=%0d exp 0/0/00/1/0", busy, out_valid, xr, in_ready, sn); end
        accept(8'h00, 8'h00);
        checks++; if (sn !== 7'd0 || busy !== 1'b1) begin failures++; $display("FAIL rmid_restart n=%0d busy=%b exp 0/1", sn, busy); end
        wait_done(n);
        checks++; if (n !== 4 || xr !== 8'h04 || yr !== 8'h00) begin failures++; $display("FAIL rmid_result cyc=%0d x=%h y=%h exp 4/04/00", n, xr, yr); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int acc[2];
        logic [7:0] rx[2], ry[2];
        int na = 0, nr = 0;
        X0 = 8'h30; Y0 = 8'h40; in_valid = 1;
        for (int c = 0; c < 15; c++) begin
            if (na == 1) begin X0 = 8'h50; Y0 = 8'h60; end
            if (na == 2) in_valid = 0;
            if (in_valid && in_ready) acc[na++] = c;
            if (out_valid && nr < 2) begin rx[nr] = xr; ry[nr] = yr; nr++; end
            @(negedge clk);
        end
        in_valid = 0;
        checks++; if (na !== 2 || acc[1] - acc[0] !== 6) begin failures++; $display("FAIL b2b_interval accepts=%0d gap=%0d exp 2/6", na, acc[1] - acc[0]); end
        checks++; if (nr !== 2) begin failures++; $display("FAIL b2b_count results=%0d exp=2", nr); end
        checks++; if (rx[0] !== 8'h34 || ry[0] !== 8'h40) begin failures++; $display("FAIL b2b_first x=%h y=%h exp 34/40", rx[0], ry[0]); end
        checks++; if (rx[1] !== 8'h54 || ry[1] !== 8'h60) begin failures++; $display("FAIL b2b_second x=%h y=%h exp 54/60", rx[1], ry[1]); end
    endtask

    task automatic test_n_iter1;
        X01 = 8'h0F; Y01 = 8'h00; in_valid1 = 1;
        #1;
        checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL n1_ready got=%b exp=1", in_ready1); end
        @(negedge clk);
        in_valid1 = 0;
        checks++; if (busy1 !== 1'b1 || sn1 !== 3'd0 || xr1 !== 8'h0F) begin failures++; $display("FAIL n1_run busy=%b n=%0d x=%h exp 1/0/0F", busy1, sn1, xr1); end
        @(negedge clk);
        checks++; if (out_valid1 !== 1'b1 || busy1 !== 1'b0 || xr1 !== 8'h10 || yr1 !== 8'h01)
            begin failures++; $display("FAIL n1_done ov=%b busy=%b x=%h y=%h exp 1/0/10/01", out_valid1, busy1, xr1, yr1); end
        @(negedge clk);
        checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin failures++; $display("FAIL n1_release ir=%b ov=%b exp 1/0", in_ready1, out_valid1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_n_iter1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
